// File: rtl/jk_flip_flop.sv
// jk_flip_flop: WIDTH independent positive-edge JK flip-flops sharing one
// clock and one asynchronous active-high reset. Each bit holds, resets, sets
// or toggles according to its own j/k pair. qb is the combinational
// complement of the state register.
//
// Optional simulation checks are compiled in when JK_FLIP_FLOP_ASSERT_EN is
// defined. They only observe the design and never change its logic.
module jk_flip_flop #(
  parameter int unsigned            WIDTH       = 1,
  parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state per bit from the JK characteristic equation:
  //   q+ = (j & ~q) | (~k & q)
  // This covers hold (00), reset (01), set (10) and toggle (11).
  // X/Z on j or k propagates through the equation rather than being masked.
  always_comb begin
    // NOTE: assign a default before any logic so that every path drives q_d
    // and no latch is inferred.
    q_d = q_q;
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // State register. Reset is asynchronous and wins over a coincident edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values.
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

`ifdef JK_FLIP_FLOP_ASSERT_EN
  // Shadow model for the one-edge-later truth-table check.
  logic [WIDTH-1:0] chk_exp_q;
  logic             chk_valid_q;

  // Capture the expected post-edge value. An asynchronous reset discards it,
  // because the state it was predicted from has been lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid_q <= 1'b0;
      chk_exp_q   <= RESET_VALUE;
    end else begin
      chk_valid_q <= 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        case ({j[i], k[i]})
          2'b00:   chk_exp_q[i] <= q_q[i];
          2'b01:   chk_exp_q[i] <= 1'b0;
          2'b10:   chk_exp_q[i] <= 1'b1;
          2'b11:   chk_exp_q[i] <= ~q_q[i];
          default: chk_exp_q[i] <= 1'bx;
        endcase
      end
    end
  end

  // Flag unknown control inputs at an active edge.
  always @(posedge clk) begin
    if (!rst && ($isunknown(j) || $isunknown(k))) begin
      $error("jk_flip_flop: j/k unknown at rising edge (j=%b k=%b)", j, k);
    end
  end

  // Mid-cycle, the state must match the prediction made at the last edge.
  always @(negedge clk) begin
    if (!rst && chk_valid_q && (q_q !== chk_exp_q)) begin
      $error("jk_flip_flop: q=%b differs from predicted %b", q_q, chk_exp_q);
    end
  end

  // The complement output must track the state at all times.
  always @(q or qb) begin
    if (qb !== ~q) begin
      $error("jk_flip_flop: qb=%b is not ~q (q=%b)", qb, q);
    end
  end
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed testbench for jk_flip_flop. A single-bit instance follows the
// hold/reset/set/toggle/async-reset sequence; a 4-bit instance with a
// non-zero reset value exercises independent bits on the same schedule.
// Inputs change on falling edges; outputs are sampled 1 ns after edges.
module tb_jk_flip_flop;

  logic       clk;
  logic       rst;
  logic       j;
  logic       k;
  logic       q;
  logic       qb;
  logic [3:0] j4;
  logic [3:0] k4;
  logic [3:0] q4;
  logic [3:0] qb4;

  int tests_run = 0;
  int tests_failed = 0;

  jk_flip_flop u_dut (
    .j   (j),
    .k   (k),
    .clk (clk),
    .rst (rst),
    .q   (q),
    .qb  (qb)
  );

  jk_flip_flop #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut4 (
    .j   (j4),
    .k   (k4),
    .clk (clk),
    .rst (rst),
    .q   (q4),
    .qb  (qb4)
  );

  // 10 ns clock, low at t=0, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Check both instances, both outputs.
  task automatic check_all(input string tag, input logic exp_q, input logic [3:0] exp_q4);
    check({tag, ".q"},   {3'b0, q},   {3'b0, exp_q});
    check({tag, ".qb"},  {3'b0, qb},  {3'b0, ~exp_q});
    check({tag, ".q4"},  q4,  exp_q4);
    check({tag, ".qb4"}, qb4, ~exp_q4);
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic jv, input logic kv, input logic [3:0] j4v, input logic [3:0] k4v);
    @(negedge clk);
    j  = jv;
    k  = kv;
    j4 = j4v;
    k4 = k4v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    j   = 1'b0;
    k   = 1'b0;
    j4  = 4'b0000;
    k4  = 4'b0000;

    #1;
    check_all("reset_t1", 1'b0, 4'b1010);
    @(posedge clk);
    #1;
    check_all("reset_across_edge", 1'b0, 4'b1010);

    // Release at t=10, hold through the edge at t=15.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("hold_after_release", 1'b0, 4'b1010);

    // t=20: single bit reset-via-K; wide bits 3,1 reset and 2,0 set.
    step(1'b0, 1'b1, 4'b0101, 4'b1010);
    check_all("k_reset", 1'b0, 4'b0101);

    // t=30: set; wide 0101 -> toggle b3, set b2, reset b1, hold b0 -> 1101.
    step(1'b1, 1'b0, 4'b1100, 4'b1010);
    check_all("set", 1'b1, 4'b1101);

    // t=40: toggle everything; 1 -> 0, 1101 -> 0010.
    step(1'b1, 1'b1, 4'b1111, 4'b1111);
    check_all("toggle_1", 1'b0, 4'b0010);

    // Keep the single bit toggling; wide instance holds.
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_all("toggle_2", 1'b1, 4'b0010);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_all("toggle_3", 1'b0, 4'b0010);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_all("toggle_4", 1'b1, 4'b0010);

    // K reset from q=1; wide 0010: hold b3, reset b2, toggle b1, set b0 -> 0001.
    step(1'b0, 1'b1, 4'b0011, 4'b0110);
    check_all("k_reset_from_1", 1'b0, 4'b0001);

    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    check_all("set_again", 1'b1, 4'b0001);
    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_all("hold_one", 1'b1, 4'b0001);

    // Mid-cycle asynchronous reset (t=107), well before the edge at t=115.
    #1;
    rst = 1'b1;
    #1;
    check_all("async_reset_immediate", 1'b0, 4'b1010);

    // Reset must win over an edge with toggle requested.
    step(1'b1, 1'b1, 4'b1111, 4'b1111);
    check_all("reset_priority", 1'b0, 4'b1010);

    // Release at t=120 with set requests; nothing changes until the edge.
    @(negedge clk);
    rst = 1'b0;
    j   = 1'b1;
    k   = 1'b0;
    j4  = 4'b0101;
    k4  = 4'b0000;
    #1;
    check_all("no_pending_update", 1'b0, 4'b1010);
    @(posedge clk);
    #1;
    check_all("first_edge_after_release", 1'b1, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #5000;
    $display("FAIL watchdog: simulation still running at t=%0t, limit 5000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
